// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared definitions for the note sequencer.
//   - note entry layout (10 bits: END, REST, 4-bit duration, 4-bit tone index)
//   - FSM state enumeration
//   - helper turning a tone index into the one-hot tone vector
package note_seq_pkg;

  localparam int ENTRY_W  = 10;
  localparam int END_BIT  = 9;
  localparam int REST_BIT = 8;
  localparam int DUR_MSB  = 7;
  localparam int DUR_LSB  = 4;
  localparam int IDX_MSB  = 3;
  localparam int IDX_LSB  = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_e;

  function automatic logic [15:0] tone_onehot(input logic [3:0] idx);
    return 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: control/loader bus and audio outputs of the sequencer.
//   master: user side (drives write port, play/stop/loop, vol_in)
//   slave : sequencer side (drives tone, volume, busy, done, note_idx)
interface note_sequencer_if #(
  parameter int AW = 5
) ();
  import note_seq_pkg::*;

  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [ENTRY_W-1:0] wr_data;
  logic               play;
  logic               stop;
  logic               loop;
  logic [7:0]         vol_in;
  logic [15:0]        tone;
  logic [7:0]         volume;
  logic               busy;
  logic               done;
  logic [AW-1:0]      note_idx;

  modport master (
    output wr_en, wr_addr, wr_data, play, stop, loop, vol_in,
    input  tone, volume, busy, done, note_idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, play, stop, loop, vol_in,
    output tone, volume, busy, done, note_idx
  );

endinterface

// File: rtl/note_sequencer_tick_gen.sv
// tick_gen: beat tick generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous restart of the divider (next cycle counts from 0)
//   tick       : high for one cycle every TICK_DIV cycles
module tick_gen #(
  parameter int TICK_DIV = 6250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] cnt_q;

  assign tick = (cnt_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr || tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: programmable melody player.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus.slave  : note RAM write port, play/stop/loop/vol_in controls,
//                one-hot tone, volume, busy, done pulse, note_idx
// Notes are fetched from a synchronous-read RAM, each held for D beat ticks
// (D=0 means 16), optionally followed by GAP_TICKS silent ticks.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int TICK_DIV  = 6250000,
  parameter int GAP_TICKS = 1,
  parameter int DEPTH     = 32,
  parameter int AW        = 5
) (
  input logic            clk,
  input logic            rst_n,
  note_sequencer_if.slave bus
);
  // Tick counter must hold both a 16-tick note and the gap length.
  localparam int TW = ($clog2(GAP_TICKS + 1) > 4) ? $clog2(GAP_TICKS + 1) : 4;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] rd_data_q;
  logic [AW-1:0]      rd_addr;
  logic [AW-1:0]      addr_q;
  logic [AW-1:0]      addr_inc;
  logic               at_end;
  state_e             state_q;
  state_e             adv_state;
  logic [15:0]        tone_q;
  logic [7:0]         volume_q;
  logic [3:0]         dur_q;
  logic [3:0]         dur_m1;
  logic [TW-1:0]      ticks_q;
  logic               tick;
  logic               tick_clr;
  logic               last_tick;

  assign at_end    = (addr_q == AW'(DEPTH - 1));
  assign addr_inc  = at_end ? '0 : addr_q + 1'b1;
  // 4-bit wrap makes duration 0 compare against 15, i.e. 16 ticks.
  assign dur_m1    = dur_q - 4'd1;
  assign adv_state = (at_end && !bus.loop) ? S_DONE : S_FETCH;

  // The read address is the address the FSM will hold in its next FETCH
  // cycle, so the registered read data is ready exactly during FETCH.
  always_comb begin
    rd_addr   = '0;
    last_tick = 1'b0;
    if (state_q == S_PLAY) begin
      rd_addr   = addr_inc;
      last_tick = tick && (ticks_q == TW'(dur_m1));
    end else if (state_q == S_GAP) begin
      rd_addr   = addr_inc;
      last_tick = tick && (ticks_q == TW'(GAP_TICKS - 1));
    end
  end

  // Divider is held cleared outside PLAY/GAP and restarted at each phase
  // boundary so every note and gap starts on a full tick period.
  assign tick_clr = !(state_q == S_PLAY || state_q == S_GAP) || last_tick;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tick_clr),
    .tick (tick)
  );

  // Note RAM: not reset, read-before-write on address collision.
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
    rd_data_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      tone_q   <= '0;
      volume_q <= '0;
      dur_q    <= '0;
      ticks_q  <= '0;
    end else if (bus.stop) begin
      state_q  <= S_IDLE;
      tone_q   <= '0;
      volume_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.play) begin
            state_q  <= S_FETCH;
            addr_q   <= '0;
            volume_q <= bus.vol_in;
          end
        end
        S_FETCH: begin
          if (rd_data_q[END_BIT]) begin
            // Looping an END found at address 0 would spin forever.
            if (bus.loop && addr_q != '0) begin
              addr_q <= '0;
            end else begin
              state_q <= S_DONE;
            end
          end else begin
            state_q <= S_PLAY;
            dur_q   <= rd_data_q[DUR_MSB:DUR_LSB];
            ticks_q <= '0;
            tone_q  <= rd_data_q[REST_BIT] ? 16'h0000
                                           : tone_onehot(rd_data_q[IDX_MSB:IDX_LSB]);
          end
        end
        S_PLAY: begin
          if (tick) begin
            ticks_q <= ticks_q + 1'b1;
          end
          if (last_tick) begin
            tone_q  <= '0;
            ticks_q <= '0;
            if (GAP_TICKS == 0) begin
              state_q <= adv_state;
              addr_q  <= addr_inc;
            end else begin
              state_q <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            ticks_q <= ticks_q + 1'b1;
          end
          if (last_tick) begin
            ticks_q <= '0;
            state_q <= adv_state;
            addr_q  <= addr_inc;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.tone     = tone_q;
  assign bus.volume   = volume_q;
  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.note_idx = addr_q;

endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed + randomized songs checked cycle by cycle
// against a song-level reference model.
module tb_note_sequencer;
  import note_seq_pkg::*;

  localparam int TICK  = 4;
  localparam int GAP   = 1;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  typedef struct packed {
    logic [15:0]   tone;
    logic [AW-1:0] idx;
    logic          busy;
    logic          done;
    logic [7:0]    vol;
  } obs_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [9:0] mref [DEPTH];
  obs_t       exp_q [$];
  bit         iv_q  [$];

  note_sequencer_if #(.AW(AW)) bus ();

  note_sequencer #(
    .TICK_DIV (TICK),
    .GAP_TICKS(GAP),
    .DEPTH    (DEPTH),
    .AW       (AW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic wr(input int a, input logic [9:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = AW'(a);
    bus.wr_data = d;
    mref[a]     = d;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
  endtask

  function automatic logic [9:0] note(input bit rest, input int dur, input int idx);
    return {1'b0, rest, 4'(dur), 4'(idx)};
  endfunction

  task automatic push(input logic [15:0] t, input int a, input bit bsy,
                      input bit dn, input logic [7:0] vol, input bit iv);
    obs_t o;
    o.tone = t;
    o.idx  = iv ? AW'(a) : '0;
    o.busy = bsy;
    o.done = dn;
    o.vol  = bsy ? vol : 8'h00;
    exp_q.push_back(o);
    iv_q.push_back(iv);
  endtask

  // Expected per-cycle outputs, starting with the cycle after play is taken.
  task automatic build_model(input bit lp, input int maxc, input logic [7:0] vol);
    int          a;
    bit          fin;
    logic [9:0]  e;
    int          d;
    logic [15:0] t;
    exp_q.delete();
    iv_q.delete();
    a   = 0;
    fin = 0;
    while (!fin && exp_q.size() < maxc) begin
      push(16'h0, 0, 1, 0, vol, 0);             // fetch cycle
      e = mref[a];
      if (e[9]) begin
        if (lp && a != 0) begin
          a = 0;
        end else begin
          push(16'h0, 0, 1, 1, vol, 0);         // done pulse
          push(16'h0, 0, 0, 0, vol, 0);         // back to idle
          fin = 1;
        end
      end else begin
        d = (e[7:4] == 0) ? 16 : int'(e[7:4]);
        t = e[8] ? 16'h0 : (16'h1 << e[3:0]);
        repeat (d * TICK) push(t, a, 1, 0, vol, 1);
        repeat (GAP * TICK) push(16'h0, a, 1, 0, vol, 1);
        if (a == DEPTH - 1) begin
          a = 0;
          if (!lp) begin
            push(16'h0, 0, 1, 1, vol, 0);
            push(16'h0, 0, 0, 0, vol, 0);
            fin = 1;
          end
        end else begin
          a++;
        end
      end
    end
    while (exp_q.size() > maxc) begin
      void'(exp_q.pop_back());
      void'(iv_q.pop_back());
    end
  endtask

  task automatic run_song(input string tag, input bit lp, input int maxc);
    logic [7:0] vol;
    obs_t       o;
    vol = 8'($urandom_range(1, 255));
    build_model(lp, maxc, vol);
    bus.loop   = lp;
    bus.vol_in = vol;
    bus.play   = 1'b1;
    @(posedge clk);
    #1;
    bus.play = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      o.tone = bus.tone;
      o.idx  = iv_q[i] ? bus.note_idx : '0;
      o.busy = bus.busy;
      o.done = bus.done;
      o.vol  = exp_q[i].busy ? bus.volume : 8'h00;
      chk($sformatf("%s cyc%0d", tag, i), 64'(o), 64'(exp_q[i]));
    end
    $display("song %s loop=%0d vol=%h: %0d cycles compared", tag, lp, vol, exp_q.size());
  endtask

  task automatic do_stop(input string tag);
    bus.stop = 1'b1;
    @(posedge clk);
    #1;
    bus.stop = 1'b0;
    chk({tag, " stop"}, {bus.tone, bus.volume, bus.busy, bus.done}, 26'h0);
    repeat (20) @(posedge clk);
    #1;
    chk({tag, " stop idle"}, {bus.busy, bus.done}, 2'b00);
    $display("stop %s: sequencer idle", tag);
  endtask

  initial begin
    int n;
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.play    = 1'b0;
    bus.stop    = 1'b0;
    bus.loop    = 1'b0;
    bus.vol_in  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset outputs", {bus.tone, bus.volume, bus.busy, bus.done, bus.note_idx}, 31'h0);
    rst_n = 1'b1;
    for (int a = 0; a < DEPTH; a++) wr(a, 10'h200);
    $display("ram cleared to END");

    // 1: single note then END
    wr(0, note(0, 3, 5));
    wr(1, 10'h200);
    run_song("t1", 0, 1000);

    // 2: rest then note
    wr(0, note(1, 2, 9));
    wr(1, note(0, 1, 0));
    wr(2, 10'h200);
    run_song("t2", 0, 1000);

    // 3: looping, then stop in the middle of entry1
    run_song("t3loop", 1, 40);
    do_stop("t3");

    // 4: duration 0 means 16 ticks
    wr(0, note(0, 0, 15));
    wr(1, 10'h200);
    run_song("t4", 0, 1000);

    // 5: full RAM without END, no loop then loop
    for (int a = 0; a < DEPTH; a++)
      wr(a, note(($urandom_range(0, 3) == 0), $urandom_range(1, 2), $urandom_range(0, 15)));
    run_song("t5full", 0, 5000);
    run_song("t5wrap", 1, exp_q.size() + 60);
    do_stop("t5");

    // random short songs
    for (int s = 0; s < 3; s++) begin
      n = $urandom_range(1, 8);
      for (int a = 0; a < n; a++)
        wr(a, note(($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 15)));
      wr(n, 10'h200);
      run_song($sformatf("rand%0d", s), 0, 5000);
    end

    // 6: asynchronous reset mid-note, RAM survives
    wr(0, note(0, 2, 7));
    wr(1, note(0, 1, 2));
    wr(2, 10'h200);
    run_song("t6part", 0, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset", {bus.tone, bus.volume, bus.busy, bus.done, bus.note_idx}, 31'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_song("t6replay", 0, 1000);

    // play and stop together in idle
    bus.play = 1'b1;
    bus.stop = 1'b1;
    @(posedge clk);
    #1;
    chk("play+stop", {bus.busy, bus.tone}, 17'h0);
    bus.play = 1'b0;
    bus.stop = 1'b0;
    @(posedge clk);
    #1;
    chk("play+stop after", {bus.busy, bus.done}, 2'b00);
    $display("play+stop in idle: stayed idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
